// File: rtl/serial_feeder_pkg.sv
// Shared types and sizing helpers for the serial bit feeder.
package serial_feeder_pkg;

  typedef enum logic [0:0] {IDLE, SHIFT} feeder_state_t;

  // Bit counter must index 0..WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-in/serial-out feeder with a one-word hold buffer for gapless streaming.
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  feeder_state_t    state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             word_done_q, word_done_d;
  logic             accept;
  logic             last_consumed;

  assign accept        = load_valid && !hold_full_q;
  assign last_consumed = (state_q == SHIFT) && shift_en && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_consumed) begin
          word_done_d = 1'b1;
          cnt_d       = '0;
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sreg_d = load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (shift_en) begin
            sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d  = cnt_q + CW'(1);
          end
          // Words arriving mid-word wait in the hold buffer.
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  always_comb begin
    bit_valid  = (state_q == SHIFT);
    bit_out    = IDLE_BIT;
    if (state_q == SHIFT) bit_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    load_ready = !hold_full_q;
    busy       = (state_q == SHIFT) || hold_full_q;
    word_done  = word_done_q;
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: vector table, directed corner sequences, random vs queue model.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       shift_en = 1'b0;
  logic       load_ready, bit_out, bit_valid, busy, word_done;
  logic       l_load_ready, l_bit_out, l_bit_valid, l_busy, l_word_done;

  int n_total = 0;
  int n_bad   = 0;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .shift_en(shift_en), .bit_out(bit_out),
    .bit_valid(bit_valid), .busy(busy), .word_done(word_done));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_load_ready), .shift_en(shift_en), .bit_out(l_bit_out),
    .bit_valid(l_bit_valid), .busy(l_busy), .word_done(l_word_done));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       sh;
    logic [4:0] exp;   // {load_ready, bit_out, bit_valid, busy, word_done}
  } vec_t;

  vec_t tbl[11];

  // Reference model: a queue of words in flight plus bits consumed of the head word.
  logic [7:0] mq[$];
  int         mpos;
  logic       mdone;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic s);
    rst = r; load_valid = v; load_data = d; shift_en = s;
  endtask

  function automatic logic [4:0] outs_m();
    return {load_ready, bit_out, bit_valid, busy, word_done};
  endfunction

  function automatic logic [4:0] outs_l();
    return {l_load_ready, l_bit_out, l_bit_valid, l_busy, l_word_done};
  endfunction

  task automatic model_edge();
    logic acc;
    acc = load_valid && (mq.size() < 2);
    mdone = 1'b0;
    if (rst) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (mq.size() > 0 && shift_en) begin
        mpos++;
        if (mpos == 8) begin
          void'(mq.pop_front());
          mpos  = 0;
          mdone = 1'b1;
        end
      end
      if (acc) mq.push_back(load_data);
    end
  endtask

  function automatic logic [4:0] model_outs(input bit msb_first);
    logic b;
    b = 1'b0;
    if (mq.size() > 0) b = msb_first ? mq[0][7-mpos] : mq[0][mpos];
    return {mq.size() < 2, b, mq.size() > 0, mq.size() > 0, mdone};
  endfunction

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  lbits;
    int          dn1, dn2, vcnt, dcnt, rcnt;
    logic        stall_bit;
    logic [7:0]  word;

    // Single word 1011_0010, MSB first, shift_en held high.
    word = 8'b1011_0010;
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'b10000};
    tbl[1] = '{1'b0, 1'b1, word,  1'b1, {1'b1, word[7], 3'b110}};
    for (int i = 2; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b1, {1'b1, word[8-i], 3'b110}};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b10001};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b10000};

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].sh);
      step();
      chk($sformatf("vec%0d", i), 32'(outs_m()), 32'(tbl[i].exp));
    end

    // Back-to-back A5 then 3C through the hold buffer.
    do_reset();
    bits = '0; dn1 = -1; dn2 = -1; vcnt = 0;
    for (int s = 1; s <= 18; s++) begin
      drive(1'b0, (s <= 2), (s == 1) ? 8'hA5 : 8'h3C, 1'b1);
      step();
      if (s <= 16) begin
        bits = {bits[14:0], bit_out};
        if (bit_valid) vcnt++;
      end
      if (word_done) begin
        if (dn1 < 0) dn1 = s; else dn2 = s;
      end
      if (s == 8) chk("b2b_ready_held", 32'(load_ready), 32'd0);
      if (s == 9) chk("b2b_ready_back", 32'(load_ready), 32'd1);
    end
    chk("b2b_bits", 32'(bits), 32'hA53C);
    chk("b2b_valid_cnt", 32'(vcnt), 32'd16);
    chk("b2b_done1", 32'(dn1), 32'd9);
    chk("b2b_done2", 32'(dn2), 32'd17);

    // Stall: shift_en low for three cycles while the third bit of F0 is shown.
    do_reset();
    vcnt = 0; dcnt = 0; stall_bit = 1'b0;
    for (int s = 1; s <= 15; s++) begin
      drive(1'b0, (s == 1), 8'hF0, !(s >= 4 && s <= 6));
      step();
      if (bit_valid) vcnt++;
      if (word_done) begin
        dcnt++;
        chk("stall_done_cycle", 32'(s), 32'd12);
      end
      if (s >= 3 && s <= 6) chk($sformatf("stall_hold%0d", s), 32'(bit_out), 32'd1);
      if (s == 7) chk("stall_next_bit", 32'(bit_out), 32'd1);
      if (s == 9) chk("stall_bit5", 32'(bit_out), 32'd0);
    end
    chk("stall_valid_cnt", 32'(vcnt), 32'd11);
    chk("stall_done_cnt", 32'(dcnt), 32'd1);

    // Load coinciding with last-bit consumption and an empty hold buffer.
    do_reset();
    bits = '0; vcnt = 0; rcnt = 0; dn1 = -1; dn2 = -1;
    for (int s = 1; s <= 17; s++) begin
      drive(1'b0, (s == 1 || s == 9), (s == 1) ? 8'h7E : 8'h81, 1'b1);
      step();
      if (s <= 16) begin
        bits = {bits[14:0], bit_out};
        if (bit_valid) vcnt++;
        if (load_ready) rcnt++;
      end
      if (word_done) begin
        if (dn1 < 0) dn1 = s; else dn2 = s;
      end
    end
    chk("seam_bits", 32'(bits), 32'h7E81);
    chk("seam_valid_cnt", 32'(vcnt), 32'd16);
    chk("seam_ready_cnt", 32'(rcnt), 32'd16);
    chk("seam_done1", 32'(dn1), 32'd9);
    chk("seam_done2", 32'(dn2), 32'd17);

    // Reset mid-word with a word held.
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      drive(1'b0, (s <= 2), (s == 1) ? 8'hCC : 8'h55, 1'b1);
      step();
    end
    chk("rst_pre_busy", 32'(busy), 32'd1);
    chk("rst_pre_ready", 32'(load_ready), 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    chk("rst_outs", 32'(outs_m()), 32'b10000);
    vcnt = 0; dcnt = 0;
    for (int s = 0; s < 12; s++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      step();
      if (bit_valid) vcnt++;
      if (word_done) dcnt++;
    end
    chk("rst_no_valid", 32'(vcnt), 32'd0);
    chk("rst_no_done", 32'(dcnt), 32'd0);

    // LSB-first instance with 0000_0110.
    do_reset();
    lbits = '0;
    for (int s = 1; s <= 8; s++) begin
      drive(1'b0, (s == 1), 8'b0000_0110, 1'b1);
      step();
      lbits = {lbits[6:0], l_bit_out};
    end
    chk("lsb_bits", 32'(lbits), 32'b0110_0000);
    step();
    chk("lsb_done", 32'(l_word_done), 32'd1);

    // Random traffic against the queue model, both bit orders.
    do_reset();
    mq.delete(); mpos = 0; mdone = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
            8'($urandom), ($urandom_range(0, 9) < 7));
      model_edge();
      step();
      chk($sformatf("rnd_msb%0d", c), 32'(outs_m()), 32'(model_outs(1'b1)));
      chk($sformatf("rnd_lsb%0d", c), 32'(outs_l()), 32'(model_outs(1'b0)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
